// File: rtl/rgb_led_pwm.sv
// Six-channel PWM driver for the two board RGB LEDs.
// Duty words arrive over valid/ready and are applied only at a PWM period wrap.
module rgb_led_pwm #(
    parameter int CLK_DIV = 392
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [47:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [5:0]  rgb,
    output logic        period_strobe
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0] PWM_LAST = 8'd254;

    logic [DIV_W-1:0] div_cnt;
    logic [7:0]       pwm_cnt;
    logic [47:0]      active;
    logic [47:0]      pending;
    logic             pend_v;
    logic             tick;
    logic             wrap;
    logic             xfer;
    logic [5:0]       cmp;

    assign tick     = en && (div_cnt == DIV_LAST);
    assign wrap     = tick && (pwm_cnt == PWM_LAST);
    assign s_tready = !pend_v && !rst;
    assign xfer     = s_tvalid && s_tready;

    // Counting only to 254 makes duty 255 compare true for the whole period.
    always_comb begin
        cmp = '0;
        for (int i = 0; i < 6; i++) begin
            cmp[i] = (pwm_cnt < active[8*i +: 8]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= wrap ? 8'd0 : pwm_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb           <= '0;
            period_strobe <= 1'b0;
        end else begin
            rgb           <= en ? cmp : 6'd0;
            period_strobe <= wrap;
        end
    end

    // A transfer needs pend_v low, so it can never collide with an apply.
    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= '0;
            pending <= '0;
            pend_v  <= 1'b0;
        end else if (wrap && pend_v) begin
            active  <= pending;
            pend_v  <= 1'b0;
        end else if (xfer) begin
            pending <= s_tdata;
            pend_v  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Bench for rgb_led_pwm: phase-based reference model plus per-period
// high-time measurements for directed and random scenarios.
module tb_rgb_led_pwm;

    localparam int CD  = 2;
    localparam int PER = 255 * CD;

    logic        clk;
    logic        rst;
    logic        en;
    logic [47:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [5:0]  rgb;
    logic        period_strobe;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    rgb_led_pwm #(.CLK_DIV(CD)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .rgb           (rgb),
        .period_strobe (period_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: one phase counter of enabled cycles within a 255*CD period;
    // the PWM position is simply phase / CD.
    int         m_run;
    int         m_pos;
    logic       m_wrap;
    logic [7:0] m_act  [6];
    logic [7:0] m_pend [6];
    logic       m_pv;
    logic [5:0] m_rgb;
    logic       m_strobe;

    assign m_pos  = m_run / CD;
    assign m_wrap = en && (m_run == PER - 1);

    always @(posedge clk) begin
        if (rst) begin
            m_run    <= 0;
            m_pv     <= 1'b0;
            m_rgb    <= '0;
            m_strobe <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                m_act[i]  <= '0;
                m_pend[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                m_rgb[i] <= en && (m_pos < int'(m_act[i]));
            end
            m_strobe <= m_wrap;
            if (m_wrap && m_pv) begin
                m_act <= m_pend;
                m_pv  <= 1'b0;
            end else if (s_tvalid && !m_pv) begin
                for (int i = 0; i < 6; i++) begin
                    m_pend[i] <= s_tdata[8*i +: 8];
                end
                m_pv <= 1'b1;
            end
            if (en) m_run <= (m_run + 1) % PER;
        end
    end

    function automatic logic [7:0] exp_vec();
        return {m_rgb, m_strobe, (!rst && !m_pv)};
    endfunction

    task automatic clk1();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [47:0] w, output bit ok);
        bit rdy;
        ok       = 1'b0;
        s_tdata  = w;
        s_tvalid = 1'b1;
        for (int k = 0; k < 2*PER + 5; k++) begin
            rdy = s_tready;
            clk1();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        s_tvalid = 1'b0;
    endtask

    function automatic logic [47:0] rand_word();
        logic [47:0] w;
        w[31:0]  = $urandom;
        w[47:32] = 16'($urandom);
        return w;
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; s_tvalid = 1'b0; s_tdata = '0;
        repeat (3) clk1();
        tests++;
        if ({rgb, period_strobe, s_tready} !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs got=%b exp=00000000", {rgb, period_strobe, s_tready});
        end
        rst = 1'b0;
        #1;
        tests++;
        if (s_tready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready got=%b exp=1", s_tready);
        end
    endtask

    task automatic test_idle();
        int last = -1;
        en = 1'b1;
        for (int k = 0; k < 1100; k++) begin
            clk1();
            tests++;
            if ({rgb, period_strobe, s_tready} !== exp_vec()) begin
                fails++;
                $display("FAIL idle_model cyc=%0d got=%b exp=%b", cyc, {rgb, period_strobe, s_tready}, exp_vec());
            end
            if (period_strobe === 1'b1) begin
                if (last >= 0) begin
                    tests++;
                    if (cyc - last !== PER) begin
                        fails++;
                        $display("FAIL idle_period got=%0d exp=%0d", cyc - last, PER);
                    end
                end
                last = cyc;
            end
        end
    endtask

    task automatic test_duty_levels();
        logic [7:0]  d [6] = '{8'd0, 8'd1, 8'd64, 8'd128, 8'd254, 8'd255};
        logic [47:0] w;
        int          hi [6];
        bit          ok;
        bit          seen = 1'b0;
        for (int i = 0; i < 6; i++) w[8*i +: 8] = d[i];
        send(w, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL duty_send accepted=%0b exp=1", ok);
        end
        for (int k = 0; k < 2*PER + 5 && !seen; k++) begin
            clk1();
            tests++;
            if ({rgb, period_strobe, s_tready} !== exp_vec()) begin
                fails++;
                $display("FAIL duty_model cyc=%0d got=%b exp=%b", cyc, {rgb, period_strobe, s_tready}, exp_vec());
            end
            seen = period_strobe && s_tready;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL duty_apply_wrap seen=%0b exp=1", seen);
        end
        hi = '{default: 0};
        for (int k = 0; k < PER; k++) begin
            clk1();
            for (int i = 0; i < 6; i++) hi[i] += int'(rgb[i]);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (hi[i] !== int'(d[i]) * CD) begin
                fails++;
                $display("FAIL duty_high_ch%0d got=%0d exp=%0d", i, hi[i], int'(d[i]) * CD);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] a = rand_word();
        logic [47:0] b = rand_word();
        int          hi [6];
        bit          ok;
        bit          seen = 1'b0;
        send(a, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL b2b_send_a accepted=%0b exp=1", ok);
        end
        s_tdata  = b;
        s_tvalid = 1'b1;
        for (int k = 0; k < 2*PER + 5 && !seen; k++) begin
            clk1();
            tests++;
            if ({rgb, period_strobe, s_tready} !== exp_vec()) begin
                fails++;
                $display("FAIL b2b_model cyc=%0d got=%b exp=%b", cyc, {rgb, period_strobe, s_tready}, exp_vec());
            end
            if (period_strobe && s_tready) begin
                seen = 1'b1;
            end else begin
                tests++;
                if (s_tready !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_ready_held cyc=%0d got=%b exp=0", cyc, s_tready);
                end
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL b2b_apply_a seen=%0b exp=1", seen);
        end
        hi = '{default: 0};
        for (int k = 0; k < PER; k++) begin
            clk1();
            if (k == 0) begin
                s_tvalid = 1'b0;
                tests++;
                if (s_tready !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_accept_b got=%b exp=0", s_tready);
                end
            end
            for (int i = 0; i < 6; i++) hi[i] += int'(rgb[i]);
        end
        tests++;
        if (period_strobe !== 1'b1) begin
            fails++;
            $display("FAIL b2b_period_len strobe=%b exp=1", period_strobe);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (hi[i] !== int'(a[8*i +: 8]) * CD) begin
                fails++;
                $display("FAIL b2b_a_high_ch%0d got=%0d exp=%0d", i, hi[i], int'(a[8*i +: 8]) * CD);
            end
        end
        hi = '{default: 0};
        for (int k = 0; k < PER; k++) begin
            clk1();
            for (int i = 0; i < 6; i++) hi[i] += int'(rgb[i]);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (hi[i] !== int'(b[8*i +: 8]) * CD) begin
                fails++;
                $display("FAIL b2b_b_high_ch%0d got=%0d exp=%0d", i, hi[i], int'(b[8*i +: 8]) * CD);
            end
        end
    endtask

    task automatic test_wrap_transfer();
        bit found = 1'b0;
        bit rose  = 1'b0;
        int n     = 0;
        for (int k = 0; k < 2*PER + 5 && !found; k++) begin
            clk1();
            found = (m_run == PER - 1) && s_tready;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL wrap_xfer_align found=%0b exp=1", found);
        end
        s_tdata  = rand_word();
        s_tvalid = 1'b1;
        clk1();
        s_tvalid = 1'b0;
        tests++;
        if ({period_strobe, s_tready} !== 2'b10) begin
            fails++;
            $display("FAIL wrap_xfer_not_applied got=%b exp=10", {period_strobe, s_tready});
        end
        for (int k = 0; k < PER + 5 && !rose; k++) begin
            clk1();
            n++;
            tests++;
            if ({rgb, period_strobe, s_tready} !== exp_vec()) begin
                fails++;
                $display("FAIL wrap_xfer_model cyc=%0d got=%b exp=%b", cyc, {rgb, period_strobe, s_tready}, exp_vec());
            end
            rose = s_tready;
        end
        tests++;
        if (n !== PER) begin
            fails++;
            $display("FAIL wrap_xfer_apply_delay got=%0d exp=%0d", n, PER);
        end
    endtask

    task automatic test_enable_gap();
        bit ok;
        bit seen  = 1'b0;
        bit found = 1'b0;
        int ls    = 0;
        send({6{8'd200}}, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL gap_send accepted=%0b exp=1", ok);
        end
        for (int k = 0; k < 2*PER + 5 && !seen; k++) begin
            clk1();
            seen = period_strobe && s_tready;
        end
        ls = cyc;
        for (int k = 0; k < PER && !found; k++) begin
            clk1();
            tests++;
            if ({rgb, period_strobe, s_tready} !== exp_vec()) begin
                fails++;
                $display("FAIL gap_model cyc=%0d got=%b exp=%b", cyc, {rgb, period_strobe, s_tready}, exp_vec());
            end
            found = (m_run == 100 * CD);
        end
        tests++;
        if (!seen || !found || rgb !== 6'h3f) begin
            fails++;
            $display("FAIL gap_setup seen=%0b found=%0b rgb=%b exp=111111", seen, found, rgb);
        end
        en = 1'b0;
        for (int k = 0; k < 50; k++) begin
            clk1();
            tests++;
            if (rgb !== 6'h00) begin
                fails++;
                $display("FAIL gap_rgb_low cyc=%0d got=%b exp=000000", cyc, rgb);
            end
        end
        en   = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 2*PER && !seen; k++) begin
            clk1();
            tests++;
            if ({rgb, period_strobe, s_tready} !== exp_vec()) begin
                fails++;
                $display("FAIL gap_resume_model cyc=%0d got=%b exp=%b", cyc, {rgb, period_strobe, s_tready}, exp_vec());
            end
            seen = period_strobe;
        end
        tests++;
        if (cyc - ls !== PER + 50) begin
            fails++;
            $display("FAIL gap_period got=%0d exp=%0d", cyc - ls, PER + 50);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit found = 1'b0;
        bit seen  = 1'b0;
        int n     = 0;
        send({6{8'd255}}, ok);
        for (int k = 0; k < PER && !found; k++) begin
            clk1();
            found = (m_run == 150 * CD);
        end
        tests++;
        if (!ok || !found || s_tready !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_setup ok=%0b found=%0b ready=%b exp=1/1/0", ok, found, s_tready);
        end
        rst = 1'b1;
        clk1();
        tests++;
        if ({rgb, period_strobe, s_tready} !== 8'h00) begin
            fails++;
            $display("FAIL rst_mid_outputs got=%b exp=00000000", {rgb, period_strobe, s_tready});
        end
        rst = 1'b0;
        #1;
        tests++;
        if (s_tready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_ready got=%b exp=1", s_tready);
        end
        for (int k = 0; k < PER + 5 && !seen; k++) begin
            clk1();
            n++;
            tests++;
            if (rgb !== 6'h00 || s_tready !== 1'b1) begin
                fails++;
                $display("FAIL rst_mid_no_apply cyc=%0d rgb=%b ready=%b exp=000000/1", cyc, rgb, s_tready);
            end
            seen = period_strobe;
        end
        tests++;
        if (n !== PER) begin
            fails++;
            $display("FAIL rst_mid_restart got=%0d exp=%0d", n, PER);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 599) == 0);
            if (!(s_tvalid && !s_tready)) begin
                s_tvalid = 1'($urandom_range(0, 1));
                s_tdata  = rand_word();
            end
            clk1();
            tests++;
            if ({rgb, period_strobe, s_tready} !== exp_vec()) begin
                fails++;
                $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, {rgb, period_strobe, s_tready}, exp_vec());
            end
        end
        rst      = 1'b0;
        s_tvalid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; s_tvalid = 1'b0; s_tdata = '0;
        test_reset();
        test_idle();
        test_duty_levels();
        test_back_to_back();
        test_wrap_transfer();
        test_enable_gap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
